// File: rtl/hwag_counter_pkg.sv
// Shared constants and types for the multi-compare counter.
// Direction and mode encodings, plus the per-edge operation decode.
package hwag_counter_pkg;

    localparam logic CNT_UP       = 1'b0;
    localparam logic CNT_DOWN     = 1'b1;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_STEP
    } cnt_op_e;

    // Priority below reset: clear, then load, then a step.
    // A sticky done blocks stepping until cleared or loaded.
    function automatic cnt_op_e sel_op(
        input logic srst,
        input logic sload,
        input logic ena,
        input logic done
    );
        cnt_op_e op;
        op = OP_HOLD;
        if (srst) begin
            op = OP_CLEAR;
        end else if (sload) begin
            op = OP_LOAD;
        end else if (ena && !done) begin
            op = OP_STEP;
        end
        return op;
    endfunction

endpackage

// File: rtl/counter_match_ch.sv
// One compare channel: registered match event and level ge flag.
// Ports: clk, rst, nxt_i (next count), upd_i (count changes this edge),
//        cmp_i (compare value), cur_i (current count), match_o, ge_o.
module counter_match_ch
    import hwag_counter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] nxt_i,
    input  logic             upd_i,
    input  logic [WIDTH-1:0] cmp_i,
    input  logic [WIDTH-1:0] cur_i,
    output logic             match_o,
    output logic             ge_o
);

    logic match_q;
    logic match_d;

    // Compare against the value being loaded into the counter so the
    // event lands in the same cycle the count first shows it.
    assign match_d = upd_i && (nxt_i == cmp_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match_o = match_q;
    assign ge_o    = (cur_i >= cmp_i);

endmodule

// File: rtl/counter_multi_compare.sv
// Modulo up/down counter with wrap/oneshot modes and N compare channels.
// Ports: clk, rst, srst, sload/dload, ena, dir, oneshot, dtop, cmp_val
//        in; dout, wrap, done, match[CHANNELS], ge[CHANNELS] out.
module counter_multi_compare
    import hwag_counter_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      srst,
    input  logic                      sload,
    input  logic [WIDTH-1:0]          dload,
    input  logic                      ena,
    input  logic                      dir,
    input  logic                      oneshot,
    input  logic [WIDTH-1:0]          dtop,
    input  logic [CHANNELS*WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0]          dout,
    output logic                      wrap,
    output logic                      done,
    output logic [CHANNELS-1:0]       match,
    output logic [CHANNELS-1:0]       ge
);

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             done_q;
    logic             done_d;
    logic             upd;
    logic             at_term;
    cnt_op_e          op;

    assign op = sel_op(srst, sload, ena, done_q);

    // Up counting treats any value at or above dtop as terminal, so a
    // load beyond the top wraps (or stops) on the next step.
    assign at_term = (dir == CNT_DOWN) ? (dout_q == '0)
                                       : (dout_q >= dtop);

    always_comb begin
        dout_d = dout_q;
        wrap_d = 1'b0;
        done_d = done_q;
        upd    = 1'b0;
        unique case (op)
            OP_CLEAR: begin
                dout_d = '0;
                done_d = 1'b0;
            end
            OP_LOAD: begin
                dout_d = dload;
                done_d = 1'b0;
                upd    = 1'b1;
            end
            OP_STEP: begin
                if (!at_term) begin
                    dout_d = (dir == CNT_DOWN) ? dout_q - WIDTH'(1)
                                               : dout_q + WIDTH'(1);
                    upd    = 1'b1;
                end else if (oneshot == MODE_ONESHOT) begin
                    // Stop: count holds, so no match event either.
                    done_d = 1'b1;
                end else begin
                    dout_d = (dir == CNT_DOWN) ? dtop : '0;
                    wrap_d = 1'b1;
                    upd    = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        counter_match_ch #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .nxt_i  (dout_d),
            .upd_i  (upd),
            .cmp_i  (cmp_val[i*WIDTH +: WIDTH]),
            .cur_i  (dout_q),
            .match_o(match[i]),
            .ge_o   (ge[i])
        );
    end

    assign dout = dout_q;
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: tb/tb_counter_multi_compare.sv
// Directed vector table plus randomized run against a counter model.
module tb_counter_multi_compare;

    localparam int W  = 8;
    localparam int CH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            srst;
    logic            sload;
    logic [W-1:0]    dload;
    logic            ena;
    logic            dir;
    logic            oneshot;
    logic [W-1:0]    dtop;
    logic [CH*W-1:0] cmp_val;
    logic [W-1:0]    dout;
    logic            wrap;
    logic            done;
    logic [CH-1:0]   match;
    logic [CH-1:0]   ge;

    int checks = 0;
    int errors = 0;

    int      m_cnt  = 0;
    bit      m_wrap = 0;
    bit      m_done = 0;
    bit [CH-1:0] m_match = '0;

    always #5 clk = ~clk;

    counter_multi_compare #(
        .WIDTH   (W),
        .CHANNELS(CH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .srst   (srst),
        .sload  (sload),
        .dload  (dload),
        .ena    (ena),
        .dir    (dir),
        .oneshot(oneshot),
        .dtop   (dtop),
        .cmp_val(cmp_val),
        .dout   (dout),
        .wrap   (wrap),
        .done   (done),
        .match  (match),
        .ge     (ge)
    );

    typedef struct {
        logic         r;
        logic         s;
        logic         l;
        logic [W-1:0] dl;
        logic         e;
        logic         d;
        logic         o;
        logic [W-1:0] tp;
        logic [W-1:0] c0;
        logic [W-1:0] c1;
        logic [W-1:0] x_dout;
        logic         x_wrap;
        logic         x_done;
        logic [1:0]   x_match;
        logic [1:0]   x_ge;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic r, input logic s, input logic l,
        input logic [W-1:0] dl, input logic e,
        input logic d, input logic o, input logic [W-1:0] tp,
        input logic [W-1:0] c0, input logic [W-1:0] c1,
        input logic [W-1:0] xd, input logic xw, input logic xn,
        input logic [1:0] xm, input logic [1:0] xg
    );
        vec_t v;
        v.r = r; v.s = s; v.l = l; v.dl = dl; v.e = e;
        v.d = d; v.o = o; v.tp = tp; v.c0 = c0; v.c1 = c1;
        v.x_dout = xd; v.x_wrap = xw; v.x_done = xn;
        v.x_match = xm; v.x_ge = xg;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int cmp_of(input int i);
        return int'(cmp_val[i*W +: W]);
    endfunction

    // Behavioural model: count as a plain integer in 0..dtop.
    task automatic model_edge();
        bit moved;
        int top;
        bit term;
        moved   = 0;
        m_wrap  = 0;
        m_match = '0;
        top     = int'(dtop);
        if (rst || srst) begin
            m_cnt  = 0;
            m_done = 0;
        end else if (sload) begin
            m_cnt  = int'(dload);
            m_done = 0;
            moved  = 1;
        end else if (ena && !m_done) begin
            term = dir ? (m_cnt == 0) : (m_cnt >= top);
            if (!term) begin
                m_cnt = dir ? m_cnt - 1 : m_cnt + 1;
                moved = 1;
            end else if (oneshot) begin
                m_done = 1;
            end else begin
                m_cnt  = dir ? top : 0;
                m_wrap = 1;
                moved  = 1;
            end
        end
        if (moved) begin
            for (int i = 0; i < CH; i++) begin
                m_match[i] = (m_cnt == cmp_of(i));
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        bit [CH-1:0] xg;
        for (int i = 0; i < CH; i++) xg[i] = (m_cnt >= cmp_of(i));
        chk({tag, " dout"}, int'(dout), m_cnt);
        chk({tag, " wrap"}, int'(wrap), int'(m_wrap));
        chk({tag, " done"}, int'(done), int'(m_done));
        chk({tag, " match"}, int'(match), int'(m_match));
        chk({tag, " ge"}, int'(ge), int'(xg));
    endtask

    task automatic apply(input vec_t v, input int k);
        rst     = v.r;
        srst    = v.s;
        sload   = v.l;
        dload   = v.dl;
        ena     = v.e;
        dir     = v.d;
        oneshot = v.o;
        dtop    = v.tp;
        cmp_val = {v.c1, v.c0};
        tick();
        chk($sformatf("v%0d dout", k), int'(dout), int'(v.x_dout));
        chk($sformatf("v%0d wrap", k), int'(wrap), int'(v.x_wrap));
        chk($sformatf("v%0d done", k), int'(done), int'(v.x_done));
        chk($sformatf("v%0d match", k), int'(match), int'(v.x_match));
        chk($sformatf("v%0d ge", k), int'(ge), int'(v.x_ge));
    endtask

    initial begin
        int nd;
        // reset with ena high: cmp0=0, cmp1=3 -> ge=01
        vq.push_back(mk(1,0,0,0,1,0,0,5,0,3, 0,0,0,2'b00,2'b01));
        vq.push_back(mk(1,0,0,0,1,0,0,5,0,3, 0,0,0,2'b00,2'b01));
        // up-wrap, dtop=5
        for (int k = 0; k < 14; k++) begin
            nd = (k + 1) % 6;
            vq.push_back(mk(0,0,0,0,1,0,0,5,200,200,
                            W'(nd), nd == 0, 0, 2'b00, 2'b00));
        end
        // down-oneshot from 3
        vq.push_back(mk(0,0,1,3,1,1,1,5,200,200, 3,0,0,2'b00,2'b00));
        vq.push_back(mk(0,0,0,0,1,1,1,5,200,200, 2,0,0,2'b00,2'b00));
        vq.push_back(mk(0,0,0,0,1,1,1,5,200,200, 1,0,0,2'b00,2'b00));
        vq.push_back(mk(0,0,0,0,1,1,1,5,200,200, 0,0,0,2'b00,2'b00));
        vq.push_back(mk(0,0,0,0,1,1,1,5,200,200, 0,0,1,2'b00,2'b00));
        vq.push_back(mk(0,0,0,0,1,1,1,5,200,200, 0,0,1,2'b00,2'b00));
        vq.push_back(mk(0,0,1,3,1,1,1,5,200,200, 3,0,0,2'b00,2'b00));
        // match: cmp0=2, cmp1=5, dtop=7, ena toggling
        vq.push_back(mk(0,0,1,0,0,0,0,7,2,5, 0,0,0,2'b00,2'b00));
        vq.push_back(mk(0,0,0,0,1,0,0,7,2,5, 1,0,0,2'b00,2'b00));
        vq.push_back(mk(0,0,0,0,1,0,0,7,2,5, 2,0,0,2'b01,2'b01));
        vq.push_back(mk(0,0,0,0,0,0,0,7,2,5, 2,0,0,2'b00,2'b01));
        vq.push_back(mk(0,0,0,0,0,0,0,7,2,5, 2,0,0,2'b00,2'b01));
        vq.push_back(mk(0,0,0,0,1,0,0,7,2,5, 3,0,0,2'b00,2'b01));
        vq.push_back(mk(0,0,0,0,1,0,0,7,2,5, 4,0,0,2'b00,2'b01));
        vq.push_back(mk(0,0,0,0,0,0,0,7,2,5, 4,0,0,2'b00,2'b01));
        vq.push_back(mk(0,0,0,0,1,0,0,7,2,5, 5,0,0,2'b10,2'b11));
        vq.push_back(mk(0,0,0,0,0,0,0,7,2,5, 5,0,0,2'b00,2'b11));
        vq.push_back(mk(0,0,0,0,1,0,0,7,2,5, 6,0,0,2'b00,2'b11));
        // priority: srst over sload/ena, then sload over ena
        vq.push_back(mk(0,0,1,4,0,0,0,7,2,5, 4,0,0,2'b00,2'b01));
        vq.push_back(mk(0,1,1,9,1,0,0,7,2,5, 0,0,0,2'b00,2'b00));
        vq.push_back(mk(0,0,1,9,1,0,0,7,2,5, 9,0,0,2'b00,2'b11));
        // load beyond top, then an up step wraps
        vq.push_back(mk(0,0,1,9,0,0,0,5,6,200, 9,0,0,2'b00,2'b01));
        vq.push_back(mk(0,0,0,0,1,0,0,5,6,200, 0,1,0,2'b00,2'b00));
        // reset while done, sload ignored under reset
        vq.push_back(mk(0,0,1,6,0,0,1,7,7,200, 6,0,0,2'b00,2'b00));
        vq.push_back(mk(0,0,0,0,1,0,1,7,7,200, 7,0,0,2'b01,2'b01));
        vq.push_back(mk(0,0,0,0,1,0,1,7,7,200, 7,0,1,2'b00,2'b01));
        vq.push_back(mk(0,0,0,0,1,0,1,7,7,200, 7,0,1,2'b00,2'b01));
        vq.push_back(mk(1,0,1,3,1,0,1,7,7,200, 0,0,0,2'b00,2'b00));
        vq.push_back(mk(0,0,0,0,1,0,1,7,7,200, 1,0,0,2'b00,2'b00));
        // dtop=0 wrap mode: wrap + match together every step
        vq.push_back(mk(0,0,0,0,1,0,0,0,0,200, 0,1,0,2'b01,2'b01));
        vq.push_back(mk(0,0,0,0,1,0,0,0,0,200, 0,1,0,2'b01,2'b01));
        vq.push_back(mk(0,0,0,0,1,1,0,0,0,200, 0,1,0,2'b01,2'b01));
        vq.push_back(mk(0,0,0,0,0,1,0,0,0,200, 0,0,0,2'b00,2'b01));

        for (int k = 0; k < vq.size(); k++) begin
            apply(vq[k], k);
        end

        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 99) < 2);
            srst    = ($urandom_range(0, 99) < 3);
            sload   = ($urandom_range(0, 99) < 8);
            ena     = ($urandom_range(0, 99) < 75);
            dir     = $urandom_range(0, 1) == 1;
            oneshot = ($urandom_range(0, 99) < 30);
            dload   = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 255))
                                                  : W'($urandom_range(0, 15));
            dtop    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                                  : W'($urandom_range(0, 12));
            cmp_val = {W'($urandom_range(0, 15)), W'($urandom_range(0, 15))};
            tick();
            check_model($sformatf("r%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_multi_compare.md
COUNTER_MULTI_COMPARE -- requirements
Module: counter_multi_compare

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter and compare value width (at least 2).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent compare channels (at least 1).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port srst, input, 1, synchronous clear of counter and status.
REQ-006 SHALL have port sload, input, 1, synchronous load of dload.
REQ-007 SHALL have port dload, input, WIDTH, load value.
REQ-008 SHALL have port ena, input, 1, count-step enable.
REQ-009 SHALL have port dir, input, 1, count direction: 0 = up, 1 = down.
REQ-010 SHALL have port oneshot, input, 1, mode: 1 = stop at terminal count, 0 = wrap.
REQ-011 SHALL have port dtop, input, WIDTH, modulo top; count range is 0..dtop.
REQ-012 SHALL have port cmp_val, input, CHANNELS*WIDTH, compare values; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-013 SHALL have port dout, output, WIDTH, current count.
REQ-014 SHALL have port wrap, output, 1, one-cycle pulse on wrap-around.
REQ-015 SHALL have port done, output, 1, sticky terminal flag (oneshot mode only).
REQ-016 SHALL have port match, output, CHANNELS, one-cycle event per channel.
REQ-017 SHALL have port ge, output, CHANNELS, level flag: dout >= cmp_val[i], unsigned, combinational from dout.

Function
REQ-018 SHALL apply per-edge priority: rst > srst > sload > count step > hold.
REQ-019 SHALL define a count step as: ena=1 and done=0.
REQ-020 SHALL, on an up step, set dout to dout+1 if dout < dtop; otherwise (dout >= dtop) take the terminal action.
REQ-021 SHALL, on a down step, set dout to dout-1 if dout != 0; otherwise (dout == 0) take the terminal action.
REQ-022 SHALL take the wrap terminal action when oneshot=0: dout becomes 0 (up) or dtop (down), and wrap=1 for the following cycle.
REQ-023 SHALL take the stop terminal action when oneshot=1: dout holds, done=1, no wrap pulse.
REQ-024 SHALL, while done=1, ignore ena; only rst, srst or sload clear done.
REQ-025 SHALL, on srst: dout=0, done=0, wrap=0, match=0.
REQ-026 SHALL, on sload: dout=dload, done=0, wrap=0.
REQ-027 SHALL register match[i]=1 for exactly one cycle when a load or step makes the new dout equal cmp_val[i].
REQ-028 SHALL align match[i] with dout, so match[i] rises in the same cycle dout first shows the matching value.
REQ-029 SHALL keep match[i]=0 while the counter holds, even if dout == cmp_val[i].
REQ-030 SHALL generate no match on srst.
REQ-031 SHALL let a wrap step to a value equal to cmp_val[i] assert wrap and match[i] together.
REQ-032 SHALL handle dtop == 0: up or down steps are terminal every cycle; wrap mode pulses wrap each step with dout=0.
REQ-033 SHALL sample dir, oneshot, dtop and cmp_val each cycle; changes take effect on the next edge, with no internal latching.
REQ-034 SHALL use WIDTH-bit modulo arithmetic only; there is no carry output.

Reset
REQ-035 SHALL, on rst=1 at a clk edge: dout=0, wrap=0, done=0, match=0; ge then reflects dout=0.
REQ-036 SHALL make rst asserted mid-count or while done=1 override all other inputs in that cycle.
REQ-037 SHALL resume counting from 0 on the first edge after rst deasserts, if ena=1.

Structure
REQ-038 SHALL place direction constants (CNT_UP, CNT_DOWN) and the mode constants in shared package hwag_counter_pkg.
REQ-039 SHALL implement each compare channel as one sub-module counter_match_ch (WIDTH), instantiated CHANNELS times by generate.
REQ-040 SHALL give counter_match_ch these inputs: next-dout value, update strobe, cmp value, clk, rst.
REQ-041 SHALL give counter_match_ch these outputs: registered match, combinational ge.
REQ-042 SHALL keep the counter datapath in the top module, with no other sub-modules.

Verification
REQ-043 SHALL cover up-wrap: WIDTH=8, dtop=5, oneshot=0, ena=1 for 14 cycles -> dout 0,1,2,3,4,5,0,1,...; wrap high exactly on the cycles dout returns to 0.
REQ-044 SHALL cover down-oneshot: sload dload=3, dir=1, oneshot=1, ena=1 -> dout 3,2,1,0 then holds 0; done=1 from the cycle after 0 is reached; done clears on sload.
REQ-045 SHALL cover match: cmp_val[0]=2, cmp_val[1]=5, dtop=7, up count with ena toggling -> match[0] one pulse at dout=2, match[1] one pulse at dout=5; no repeat while held at 2.
REQ-046 SHALL cover priority: srst=1, sload=1 and ena=1 on the same edge with dout=4 -> dout=0, match=0; sload+ena with dload=9 -> dout=9, not 10.
REQ-047 SHALL cover load beyond top: dtop=5, sload dload=9, up step -> dout=0 with wrap=1; ge[i] for cmp_val=6 is 1 before the step and 0 after.
REQ-048 SHALL cover mid-operation reset: done=1 with dout=7, rst=1 for one edge -> dout=0, done=0, counting restarts next edge.
